// File: rtl/jtframe_inputrec.sv
// jtframe_inputrec
// Records or plays back the packed game input word, one word per vertical
// sync. The controller owns a single-port synchronous RAM and shares it
// between a record sequencer and a playback sequencer. While idle or
// recording, live inputs pass through to the game core. During playback,
// the RAM contents replace them.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   vs                vertical sync (active high, synchronous to clk)
//   rec_start         level; starts recording (sampled only in IDLE)
//   play_start        level; starts playback (sampled only in IDLE, needs rec_len != 0)
//   stop              level; aborts recording or playback
//   joy_in            live input word
//   joy_out           registered input word sent to the game core
//   ram_addr/din/we   registered RAM interface; ram_we is a one-cycle pulse
//   ram_dout          RAM read data, valid one clock after ram_addr
//   recording/playing state flags
//   full              the last recording ended because the RAM was exhausted
//   rec_len           number of recorded frames, 0 .. 2**AW
module jtframe_inputrec #(
  parameter int unsigned DW   = 16,
  parameter int unsigned AW   = 12,
  parameter int unsigned LOOP = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vs,
  input  logic          rec_start,
  input  logic          play_start,
  input  logic          stop,
  input  logic [DW-1:0] joy_in,
  output logic [DW-1:0] joy_out,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout,
  output logic          recording,
  output logic          playing,
  output logic          full,
  output logic [AW:0]   rec_len
);

  // Counters are one bit wider than the address, so a full RAM (2**AW) can be represented
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] LAST_ADDR = {1'b0, {AW{1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    PLAY = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic          vs_l, vs_l_nx;
  logic          armed, armed_nx;
  logic [CW-1:0] waddr, waddr_nx;
  logic [CW-1:0] raddr, raddr_nx;
  logic          rd_p1, rd_p1_nx;
  logic          rd_p2, rd_p2_nx;
  logic          rd_p3, rd_p3_nx;
  logic [DW-1:0] rd_q, rd_q_nx;
  logic [DW-1:0] joy_out_nx;
  logic [AW-1:0] ram_addr_nx;
  logic [DW-1:0] ram_din_nx;
  logic          ram_we_nx;
  logic          recording_nx;
  logic          playing_nx;
  logic          full_nx;
  logic [CW-1:0] rec_len_nx;
  logic          tick;

  // Rising edge of vs. 'armed' blocks a false edge in the first cycle after reset.
  assign tick = vs & ~vs_l & armed;

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vs_l      <= 1'b0;
      armed     <= 1'b0;
      waddr     <= '0;
      raddr     <= '0;
      rd_p1     <= 1'b0;
      rd_p2     <= 1'b0;
      rd_p3     <= 1'b0;
      rd_q      <= '0;
      joy_out   <= '0;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_we    <= 1'b0;
      recording <= 1'b0;
      playing   <= 1'b0;
      full      <= 1'b0;
      rec_len   <= '0;
    end else begin
      state     <= state_nx;
      vs_l      <= vs_l_nx;
      armed     <= armed_nx;
      waddr     <= waddr_nx;
      raddr     <= raddr_nx;
      rd_p1     <= rd_p1_nx;
      rd_p2     <= rd_p2_nx;
      rd_p3     <= rd_p3_nx;
      rd_q      <= rd_q_nx;
      joy_out   <= joy_out_nx;
      ram_addr  <= ram_addr_nx;
      ram_din   <= ram_din_nx;
      ram_we    <= ram_we_nx;
      recording <= recording_nx;
      playing   <= playing_nx;
      full      <= full_nx;
      rec_len   <= rec_len_nx;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx    = state;
    vs_l_nx     = vs;
    armed_nx    = 1'b1;
    waddr_nx    = waddr;
    raddr_nx    = raddr;
    joy_out_nx  = joy_out;
    ram_addr_nx = ram_addr;
    ram_din_nx  = ram_din;
    ram_we_nx   = 1'b0;
    full_nx     = full;
    rec_len_nx  = rec_len;
    // Read pipeline: address out, RAM access, capture data, update joy_out
    rd_p1_nx    = 1'b0;
    rd_p2_nx    = rd_p1;
    rd_p3_nx    = rd_p2;
    rd_q_nx     = rd_p2 ? ram_dout : rd_q;

    unique case (state)
      IDLE: begin
        joy_out_nx = joy_in;
        rd_p2_nx   = 1'b0;
        rd_p3_nx   = 1'b0;
        if (rec_start) begin
          state_nx   = REC;
          waddr_nx   = '0;
          rec_len_nx = '0;
          full_nx    = 1'b0;
        end else if (play_start && (rec_len != '0)) begin
          state_nx = PLAY;
          raddr_nx = '0;
        end
      end

      REC: begin
        joy_out_nx = joy_in;
        rd_p2_nx   = 1'b0;
        rd_p3_nx   = 1'b0;
        // stop has priority over a coincident tick, so no write happens
        if (stop) begin
          state_nx = IDLE;
        end else if (tick) begin
          ram_addr_nx = waddr[AW-1:0];
          ram_din_nx  = joy_in;
          ram_we_nx   = 1'b1;
          waddr_nx    = waddr + CW'(1);
          rec_len_nx  = waddr + CW'(1);
          if (waddr == LAST_ADDR) begin
            full_nx  = 1'b1;
            state_nx = IDLE;
          end
        end
      end

      PLAY: begin
        if (stop) begin
          // Drop reads still in flight. A late ram_dout never reaches joy_out.
          state_nx = IDLE;
          rd_p2_nx = 1'b0;
          rd_p3_nx = 1'b0;
        end else begin
          if (rd_p3) begin
            joy_out_nx = rd_q;
          end
          if (tick) begin
            if (raddr < rec_len) begin
              ram_addr_nx = raddr[AW-1:0];
              raddr_nx    = raddr + CW'(1);
              rd_p1_nx    = 1'b1;
            end else if (LOOP != 0) begin
              ram_addr_nx = '0;
              raddr_nx    = CW'(1);
              rd_p1_nx    = 1'b1;
            end else begin
              state_nx = IDLE;
            end
          end
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    recording_nx = (state_nx == REC);
    playing_nx   = (state_nx == PLAY);
  end

endmodule

// File: tb/tb_jtframe_inputrec.sv
// Bench for jtframe_inputrec. Two instances (LOOP=0 and LOOP=1, AW=2) share
// the same stimulus. A frame-level reference model predicts timed
// expectations into a queue, and a monitor applies and compares them on
// every cycle.
module tb_jtframe_inputrec;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 2;
  localparam int DEPTH = 4;
  localparam int JOY = 0, ADR = 1, WR = 2;

  typedef struct {
    int inst;
    int due;
    int kind;
    logic [DW-1:0] val;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, vs = 1'b0;
  logic rec_start = 1'b0, play_start = 1'b0, stop = 1'b0;
  logic [DW-1:0] joy_in = '0;
  logic [DW-1:0] joy_out [2];
  logic [DW-1:0] ram_din [2];
  logic [DW-1:0] ram_dout [2];
  logic [AW-1:0] ram_addr [2];
  logic ram_we [2];
  logic recording [2];
  logic playing [2];
  logic full [2];
  logic [AW:0] rec_len [2];
  logic [DW-1:0] mem [2][DEPTH];

  // reference model state
  int mode [2];          // 0 idle, 1 recording, 2 playing
  logic [DW-1:0] recm [2][DEPTH];
  int rlen [2];
  int idx [2];
  bit fullm [2];
  bit prev_v = 1'b0, prev_r = 1'b1, mon_en = 1'b0;
  int cyc = 0;
  exp_t eq[$];
  logic [DW-1:0] ej [2];
  logic [DW-1:0] ed [2];
  logic [AW-1:0] ea [2];
  bit ew [2];
  int total = 0, bad = 0;

  jtframe_inputrec #(.DW(DW), .AW(AW), .LOOP(0)) dut0 (
    .clk(clk), .rst(rst), .vs(vs), .rec_start(rec_start), .play_start(play_start),
    .stop(stop), .joy_in(joy_in), .joy_out(joy_out[0]), .ram_addr(ram_addr[0]),
    .ram_din(ram_din[0]), .ram_we(ram_we[0]), .ram_dout(ram_dout[0]),
    .recording(recording[0]), .playing(playing[0]), .full(full[0]), .rec_len(rec_len[0]));

  jtframe_inputrec #(.DW(DW), .AW(AW), .LOOP(1)) dut1 (
    .clk(clk), .rst(rst), .vs(vs), .rec_start(rec_start), .play_start(play_start),
    .stop(stop), .joy_in(joy_in), .joy_out(joy_out[1]), .ram_addr(ram_addr[1]),
    .ram_din(ram_din[1]), .ram_we(ram_we[1]), .ram_dout(ram_dout[1]),
    .recording(recording[1]), .playing(playing[1]), .full(full[1]), .rec_len(rec_len[1]));

  always #5 clk = ~clk;

  // single-port synchronous RAMs, 1-clk read latency
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ram_we[i]) mem[i][ram_addr[i]] <= ram_din[i];
      ram_dout[i] <= mem[i][ram_addr[i]];
    end
  end

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d: got %0h expected %0h", nm, i, cyc, act, exp);
    end
  endtask

  function automatic void push(int i, int due, int kind, logic [DW-1:0] val);
    exp_t e;
    e.inst = i; e.due = due; e.kind = kind; e.val = val;
    eq.push_back(e);
  endfunction

  function automatic void drop(int i, int from);
    for (int n = eq.size() - 1; n >= 0; n--)
      if (eq[n].inst == i && eq[n].due >= from) eq.delete(n);
  endfunction

  // Reference behavior of one instance for the clock edge k
  function automatic void model(int i, int k, bit r, bit tk, bit rs, bit ps, bit st,
                                logic [DW-1:0] w);
    if (r) begin
      mode[i] = 0; rlen[i] = 0; fullm[i] = 1'b0; idx[i] = 0;
      drop(i, k);
      push(i, k, JOY, '0);
      push(i, k, ADR, '0);
    end else begin
      case (mode[i])
        0: begin
          push(i, k, JOY, w);
          if (rs) begin
            mode[i] = 1; rlen[i] = 0; fullm[i] = 1'b0;
          end else if (ps && rlen[i] != 0) begin
            mode[i] = 2; idx[i] = 0;
          end
        end
        1: begin
          push(i, k, JOY, w);
          if (st) mode[i] = 0;
          else if (tk) begin
            push(i, k, ADR, DW'(rlen[i]));
            push(i, k, WR, w);
            recm[i][rlen[i]] = w;
            rlen[i]++;
            if (rlen[i] == DEPTH) begin
              fullm[i] = 1'b1; mode[i] = 0;
            end
          end
        end
        default: begin
          if (st) begin
            mode[i] = 0; drop(i, k);
          end else if (tk) begin
            if (idx[i] < rlen[i]) begin
              push(i, k, ADR, DW'(idx[i]));
              push(i, k + 3, JOY, recm[i][idx[i]]);
              idx[i]++;
            end else if (i == 1) begin
              push(i, k, ADR, '0);
              push(i, k + 3, JOY, recm[i][0]);
              idx[i] = 1;
            end else begin
              mode[i] = 0; drop(i, k + 1);
            end
          end
        end
      endcase
    end
  endfunction

  task automatic step(bit r, bit v, bit rs, bit ps, bit st, logic [DW-1:0] w);
    int k;
    bit tk;
    @(negedge clk);
    rst = r; vs = v; rec_start = rs; play_start = ps; stop = st; joy_in = w;
    k = cyc + 1;
    tk = v && !prev_v && !prev_r;
    prev_v = r ? 1'b0 : v;
    prev_r = r;
    for (int i = 0; i < 2; i++) model(i, k, r, tk, rs, ps, st, w);
    if (r) mon_en = 1'b1;
  endtask

  // one frame: vs pulse of one cycle followed by three low cycles
  task automatic frame(logic [DW-1:0] w);
    step(0, 1, 0, 0, 0, w);
    for (int n = 0; n < 3; n++) step(0, 0, 0, 0, 0, w);
  endtask

  task automatic idle(int n);
    for (int m = 0; m < n; m++) step(0, 0, 0, 0, 0, DW'($urandom));
  endtask

  // monitor: apply expectations that fall due, then compare every output
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (mon_en) begin
        ew[0] = 1'b0; ew[1] = 1'b0;
        for (int n = eq.size() - 1; n >= 0; n--) begin
          if (eq[n].due <= cyc) begin
            case (eq[n].kind)
              JOY: ej[eq[n].inst] = eq[n].val;
              ADR: ea[eq[n].inst] = AW'(eq[n].val);
              default: begin
                ew[eq[n].inst] = 1'b1;
                ed[eq[n].inst] = eq[n].val;
              end
            endcase
            eq.delete(n);
          end
        end
        for (int i = 0; i < 2; i++) begin
          chk("joy_out", i, 32'(joy_out[i]), 32'(ej[i]));
          chk("ram_addr", i, 32'(ram_addr[i]), 32'(ea[i]));
          chk("ram_we", i, 32'(ram_we[i]), 32'(ew[i]));
          if (ew[i]) chk("ram_din", i, 32'(ram_din[i]), 32'(ed[i]));
          chk("recording", i, 32'(recording[i]), 32'(mode[i] == 1));
          chk("playing", i, 32'(playing[i]), 32'(mode[i] == 2));
          chk("full", i, 32'(full[i]), 32'(fullm[i]));
          chk("rec_len", i, 32'(rec_len[i]), 32'(rlen[i]));
        end
      end
    end
  end

  initial begin
    repeat (3) step(1, 0, 0, 0, 0, '0);
    @(posedge clk); #2;
    for (int i = 0; i < 2; i++) chk("ram_din_reset", i, 32'(ram_din[i]), 32'h0);
    // passthrough
    step(0, 0, 0, 0, 0, 16'h1234);
    step(0, 0, 0, 0, 0, 16'h1234);
    idle(2);
    // play_start with nothing recorded stays idle
    step(0, 0, 0, 1, 0, 16'h0055);
    idle(2);
    // rec_start wins over play_start; record A1,B2,C3 then stop
    step(0, 0, 1, 1, 0, 16'h0001);
    frame(16'h00A1); frame(16'h00B2); frame(16'h00C3);
    step(0, 0, 0, 0, 1, 16'h0002);
    idle(2);
    // playback: 4th tick ends LOOP=0, wraps LOOP=1; then stop
    step(0, 0, 0, 1, 0, 16'h0003);
    frame(16'h1111); frame(16'h2222); frame(16'h3333); frame(16'h4444);
    idle(4);
    step(0, 0, 0, 0, 1, 16'h0004);
    idle(2);
    // stop coinciding with a tick inside REC
    step(0, 0, 1, 0, 0, 16'h0005);
    frame(16'h0F0F);
    step(0, 1, 0, 0, 1, 16'hDEAD);
    idle(3);
    // RAM exhaustion: 6 ticks, only 4 writes
    step(0, 0, 1, 0, 0, 16'h0006);
    for (int n = 0; n < 6; n++) frame(DW'(16'h0100 + n));
    idle(2);
    // LOOP playback of X,Y with mid-playback reset
    step(0, 0, 1, 0, 0, 16'h0007);
    frame(16'hAAAA); frame(16'hBBBB);
    step(0, 0, 0, 0, 1, 16'h0008);
    step(0, 0, 0, 1, 0, 16'h0009);
    for (int n = 0; n < 5; n++) frame(DW'($urandom));
    step(0, 1, 0, 0, 0, 16'h0010);
    step(0, 0, 0, 0, 0, 16'h0011);
    step(1, 0, 0, 0, 0, 16'h0012);
    idle(3);
    // random traffic
    for (int n = 0; n < 4000; n++) begin
      step(($urandom % 400) == 0, ($urandom % 3) == 0, ($urandom % 25) == 0,
           ($urandom % 8) == 0, ($urandom % 40) == 0, DW'($urandom));
    end
    idle(6);
    @(posedge clk); #2;
    total++;
    if (eq.size() != 0) begin
      bad++;
      $display("FAIL leftover_expectations: got %0d entries expected 0", eq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
